// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        FLUSHED = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC handshake, instruction-memory read port and decode-side output.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic [31:0] pc_in;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        input  pc_in, imem_rdata, flush, id_ready,
        output pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output pc_in, imem_rdata, flush, id_ready,
        input  pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {pc, instr} pairs with synchronous clear.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  fetchEntry_t pushData,
    output logic [1:0]  count,
    output fetchEntry_t head
);

    fetchEntry_t mem [2];
    logic        wrPtr;
    logic        rdPtr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wrPtr <= ~wrPtr;
            if (pop)  rdPtr <= ~rdPtr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign head = mem[rdPtr];

    // The issue logic reserves a slot before every read, so these can never fire.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            assert (!(push && count == 2'(DEPTH)));
            assert (!(pop && count == 2'd0));
            assert (count <= 2'(DEPTH));
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one-cycle-latency memory reads and buffers results for decode.
//   state   | meaning
//   IDLE    | first cycle out of reset, nothing issued
//   RUN     | issuing reads whenever a buffer slot is free or being freed
//   FLUSHED | cycle after a flush; PC is loading the branch target, nothing issued
module instr_fetch #(
    parameter int          FIFO_DEPTH = fetch_pkg::FIFO_DEPTH,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
    import fetch_pkg::*;

    fetchState_t state;
    fetchState_t nextState;
    logic        inflight;
    logic [31:0] inflightPc;
    logic [1:0]  count;
    fetchEntry_t head;
    fetchEntry_t pushData;
    logic [2:0]  occupancy;
    logic        ifValid;
    logic        pop;
    logic        push;
    logic        issue;

    // Buffered entries plus the read still in flight must fit the buffer.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign ifValid   = !reset && (count != 2'd0);
    assign pop       = ifValid && bus.id_ready;
    assign push      = inflight && !bus.flush && !reset;
    assign issue     = !reset && (state == RUN) && !bus.flush &&
                       ((occupancy < 3'(FIFO_DEPTH)) ||
                        ((occupancy == 3'(FIFO_DEPTH)) && pop));
    assign pushData  = '{pc: inflightPc, instr: bus.imem_rdata};

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.flush),
        .push    (push),
        .pop     (pop),
        .pushData(pushData),
        .count   (count),
        .head    (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            inflight   <= 1'b0;
            inflightPc <= 32'd0;
        end else begin
            state    <= nextState;
            inflight <= issue;
            if (issue) inflightPc <= bus.pc_in;
        end
    end

    always_comb begin
        nextState     = state;
        bus.imem_req  = issue;
        bus.imem_addr = bus.pc_in;
        bus.pc_stall  = !issue;
        bus.if_valid  = ifValid;
        bus.if_instr  = NOP_INSTR;
        bus.if_pc     = 32'd0;

        case (state)
            IDLE:    nextState = bus.flush ? FLUSHED : RUN;
            RUN:     nextState = bus.flush ? FLUSHED : RUN;
            FLUSHED: nextState = bus.flush ? FLUSHED : RUN;
            default: nextState = IDLE;
        endcase

        // Let the PC load the branch target on flush; reset holds it regardless.
        if (reset)          bus.pc_stall = 1'b1;
        else if (bus.flush) bus.pc_stall = 1'b0;

        if (ifValid) begin
            bus.if_instr = head.instr;
            bus.if_pc    = head.pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomised-ready checks of instr_fetch against a PC/imem environment model.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int passCount = 0;
    int totalCount = 0;
    logic [31:0] flushTarget = 32'd0;
    logic [31:0] expPc = 32'd0;

    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(
        .FIFO_DEPTH(2),
        .NOP_INSTR (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: memory answers last cycle's request, PC holds/advances/loads target.
    task automatic step();
        logic        req;
        logic        stall;
        logic        fl;
        logic        rst;
        logic [31:0] addr;
        req   = bus.imem_req;
        stall = bus.pc_stall;
        fl    = bus.flush;
        rst   = reset;
        addr  = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rdata = req ? memWord(addr) : 32'hDEAD_BEEF;
        if (fl && !rst)  bus.pc_in = flushTarget;
        else if (!stall) bus.pc_in = bus.pc_in + 32'd1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.id_ready = 1'b1;
        bus.pc_in = 32'd0;
        bus.imem_rdata = 32'd0;
        #1;
        step();
        step();
        totalCount++;
        if ({bus.imem_req, bus.pc_stall, bus.if_valid} !== 3'b010)
            $display("FAIL reset_ctrl: got req/stall/valid=%b want 010", {bus.imem_req, bus.pc_stall, bus.if_valid});
        else passCount++;
        totalCount++;
        if ({bus.if_instr, bus.if_pc} !== {NOP, 32'd0})
            $display("FAIL reset_data: got instr=%h pc=%h want %h/0", bus.if_instr, bus.if_pc, NOP);
        else passCount++;
        reset = 1'b0;
        #1;
        totalCount++;
        if ({bus.imem_req, bus.pc_stall, bus.if_valid} !== 3'b010)
            $display("FAIL post_reset_ctrl: got req/stall/valid=%b want 010", {bus.imem_req, bus.pc_stall, bus.if_valid});
        else passCount++;
    endtask

    task automatic test_stream();
        step();
        totalCount++;
        if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'd0, 1'b0})
            $display("FAIL stream_first_issue: got req=%b addr=%h valid=%b want 1/0/0", bus.imem_req, bus.imem_addr, bus.if_valid);
        else passCount++;
        step();
        totalCount++;
        if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'd1, 1'b0})
            $display("FAIL stream_second_issue: got req=%b addr=%h valid=%b want 1/1/0", bus.imem_req, bus.imem_addr, bus.if_valid);
        else passCount++;
        step();
        for (int i = 0; i < 4; i++) begin
            totalCount++;
            if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'(i), memWord(32'(i))})
                $display("FAIL stream_out: got valid=%b pc=%h instr=%h want 1/%h/%h", bus.if_valid, bus.if_pc, bus.if_instr, i, memWord(32'(i)));
            else passCount++;
            step();
        end
        expPc = 32'd4;
    endtask

    task automatic test_backpressure();
        bus.id_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            totalCount++;
            if ({bus.pc_stall, bus.imem_req, bus.if_valid, bus.if_pc} !== {1'b1, 1'b0, 1'b1, expPc})
                $display("FAIL stall_hold: got stall=%b req=%b valid=%b pc=%h want 1/0/1/%h", bus.pc_stall, bus.imem_req, bus.if_valid, bus.if_pc, expPc);
            else passCount++;
            step();
        end
        totalCount++;
        if (dut.fifo.count !== 2'd2)
            $display("FAIL stall_full: got count=%0d want 2", dut.fifo.count);
        else passCount++;
        bus.id_ready = 1'b1;
        #1;
        totalCount++;
        if (bus.imem_req !== 1'b1)
            $display("FAIL stall_resume_issue: got req=%b want 1", bus.imem_req);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            totalCount++;
            if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, expPc, memWord(expPc)})
                $display("FAIL stall_resume_out: got valid=%b pc=%h want 1/%h", bus.if_valid, bus.if_pc, expPc);
            else passCount++;
            expPc = expPc + 32'd1;
            step();
        end
    endtask

    task automatic test_flush_full();
        bus.id_ready = 1'b0;
        #1;
        step();
        step();
        step();
        flushTarget = 32'h40;
        bus.flush = 1'b1;
        #1;
        totalCount++;
        if ({bus.pc_stall, bus.imem_req} !== 2'b00)
            $display("FAIL flush_ctrl: got stall/req=%b want 00", {bus.pc_stall, bus.imem_req});
        else passCount++;
        step();
        bus.flush = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            totalCount++;
            if (bus.if_valid !== 1'b0)
                $display("FAIL flush_bubble: got valid=%b want 0 (cycle %0d)", bus.if_valid, i);
            else passCount++;
            if (i == 1) begin
                totalCount++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h40})
                    $display("FAIL flush_refetch: got req=%b addr=%h want 1/40", bus.imem_req, bus.imem_addr);
                else passCount++;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            totalCount++;
            if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h40 + 32'(i), memWord(32'h40 + 32'(i))})
                $display("FAIL flush_target_out: got valid=%b pc=%h want 1/%h", bus.if_valid, bus.if_pc, 32'h40 + 32'(i));
            else passCount++;
            step();
        end
    endtask

    task automatic test_flush_with_pop();
        flushTarget = 32'h80;
        bus.flush = 1'b1;
        #1;
        step();
        bus.flush = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            totalCount++;
            if (bus.if_valid !== 1'b0)
                $display("FAIL flushpop_bubble: got valid=%b want 0", bus.if_valid);
            else passCount++;
            step();
        end
        totalCount++;
        if ({bus.if_valid, bus.if_pc} !== {1'b1, 32'h80})
            $display("FAIL flushpop_out: got valid=%b pc=%h want 1/80", bus.if_valid, bus.if_pc);
        else passCount++;
        step();
    endtask

    task automatic test_flush_after_reset();
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
        bus.pc_in = 32'h100;
        flushTarget = 32'h200;
        bus.flush = 1'b1;
        #1;
        totalCount++;
        if ({bus.imem_req, bus.pc_stall, bus.if_valid} !== 3'b000)
            $display("FAIL idle_flush_ctrl: got req/stall/valid=%b want 000", {bus.imem_req, bus.pc_stall, bus.if_valid});
        else passCount++;
        step();
        bus.flush = 1'b0;
        #1;
        totalCount++;
        if ({dut.state, bus.imem_req} !== {FLUSHED, 1'b0})
            $display("FAIL idle_flush_state: got state=%0d req=%b want %0d/0", dut.state, bus.imem_req, FLUSHED);
        else passCount++;
        step();
        totalCount++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200})
            $display("FAIL idle_flush_issue: got req=%b addr=%h want 1/200", bus.imem_req, bus.imem_addr);
        else passCount++;
        step();
        step();
        totalCount++;
        if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h200, memWord(32'h200)})
            $display("FAIL idle_flush_out: got valid=%b pc=%h want 1/200", bus.if_valid, bus.if_pc);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] held;
        step();
        held = bus.pc_in;
        reset = 1'b1;
        #1;
        totalCount++;
        if ({bus.imem_req, bus.pc_stall, bus.if_valid} !== 3'b010)
            $display("FAIL midreset_ctrl: got req/stall/valid=%b want 010", {bus.imem_req, bus.pc_stall, bus.if_valid});
        else passCount++;
        step();
        reset = 1'b0;
        #1;
        totalCount++;
        if ({bus.if_valid, dut.fifo.count, dut.inflight} !== {1'b0, 2'd0, 1'b0})
            $display("FAIL midreset_clear: got valid=%b count=%0d inflight=%b want 0/0/0", bus.if_valid, dut.fifo.count, dut.inflight);
        else passCount++;
        step();
        step();
        totalCount++;
        if (bus.if_valid !== 1'b0)
            $display("FAIL midreset_stale: got valid=%b pc=%h want 0", bus.if_valid, bus.if_pc);
        else passCount++;
        step();
        totalCount++;
        if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, held, memWord(held)})
            $display("FAIL midreset_out: got valid=%b pc=%h want 1/%h", bus.if_valid, bus.if_pc, held);
        else passCount++;
    endtask

    task automatic test_random();
        logic [31:0] expNext;
        logic        doFlush;
        int          pops;
        pops = 0;
        flushTarget = 32'h1000;
        bus.flush = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        step();
        bus.flush = 1'b0;
        expNext = 32'h1000;
        for (int i = 0; i < 1000; i++) begin
            bus.id_ready = 1'($urandom_range(1, 0));
            doFlush = ($urandom_range(31, 0) == 0);
            bus.flush = doFlush;
            if (doFlush) flushTarget = $urandom & 32'h000F_FFF0;
            #1;
            if (!doFlush && bus.if_valid && bus.id_ready) begin
                totalCount++;
                if ({bus.if_pc, bus.if_instr} !== {expNext, memWord(expNext)})
                    $display("FAIL rand_seq: got pc=%h instr=%h want %h/%h at iter %0d", bus.if_pc, bus.if_instr, expNext, memWord(expNext), i);
                else passCount++;
                expNext = expNext + 32'd1;
                pops++;
            end
            if (!bus.if_valid) begin
                totalCount++;
                if ({bus.if_instr, bus.if_pc} !== {NOP, 32'd0})
                    $display("FAIL rand_empty: got instr=%h pc=%h want %h/0", bus.if_instr, bus.if_pc, NOP);
                else passCount++;
            end
            if (doFlush) expNext = flushTarget;
            totalCount++;
            if (!(dut.fifo.count <= 2'd2))
                $display("FAIL rand_count: got count=%0d want <=2", dut.fifo.count);
            else passCount++;
            step();
        end
        bus.flush = 1'b0;
        bus.id_ready = 1'b1;
        totalCount++;
        if (pops < 150)
            $display("FAIL rand_progress: got %0d pops want >=150", pops);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_with_pop();
        test_flush_after_reset();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passCount, totalCount);
        $fatal(1, "watchdog");
    end

endmodule
